// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC and FSM encoding for the fetch stage.
// ICACHE_LINES is only meaningful when the design is built with ICACHE_EN.
package inst_fetch_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned INST_WIDTH   = 32;
    localparam int unsigned ICACHE_LINES = 64;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup, synchronous fill.
// Addresses arrive as word addresses (byte offset already stripped). Used only with ICACHE_EN.
module inst_fetch_icache #(
    parameter int unsigned WordWidth = 30,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Lines     = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WordWidth-1:0] lookup_word_i,
    output logic                 hit_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 fill_i,
    input  logic [WordWidth-1:0] fill_word_i,
    input  logic [DataWidth-1:0] fill_data_i
);

    localparam int unsigned IdxW = $clog2(Lines);
    localparam int unsigned TagW = WordWidth - IdxW;

    logic [Lines-1:0]     valid_q;
    logic [TagW-1:0]      tag_q  [Lines];
    logic [DataWidth-1:0] data_q [Lines];

    logic [IdxW-1:0] lookup_idx, fill_idx;
    logic [TagW-1:0] lookup_tag, fill_tag;

    assign lookup_idx = lookup_word_i[IdxW-1:0];
    assign lookup_tag = lookup_word_i[WordWidth-1:IdxW];
    assign fill_idx   = fill_word_i[IdxW-1:0];
    assign fill_tag   = fill_word_i[WordWidth-1:IdxW];

    assign hit_o  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign data_o = data_q[lookup_idx];

    // Only the valid bits need reset; tag/data are don't-care until a line is filled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: sequential PC+4 fetch into the instruction queue, redirect on ROB refresh.
// Define ICACHE_EN to add a direct-mapped icache that serves hits without a memory request.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  inst_req_mc_out,
    output logic [ADDR_WIDTH-1:0] inst_addr_mc_out,
    input  logic [INST_WIDTH-1:0] inst_mc_in,
    input  logic                  inst_done_mc_in,
    output logic [INST_WIDTH-1:0] inst_iq_out,
    output logic [ADDR_WIDTH-1:0] pc_iq_out,
    output logic                  rdy_iq_out,
    input  logic                  iq_full_iq_in,
    input  logic                  refresh_rob_cdb_in,
    input  logic [ADDR_WIDTH-1:0] pc_rob_cdb_in
);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_seq;

    assign pc_seq = pc_q + ADDR_WIDTH'(4);

`ifdef ICACHE_EN
    logic                  cache_hit;
    logic [INST_WIDTH-1:0] cache_data;
    logic                  cache_fill;

    // Fills use the address of the outstanding request, so FLUSH-discarded data still lands.
    assign cache_fill = rdy_in && inst_done_mc_in && (state_q != StIdle);

    inst_fetch_icache #(
        .WordWidth (ADDR_WIDTH - 2),
        .DataWidth (INST_WIDTH),
        .Lines     (ICACHE_LINES)
    ) u_icache (
        .clk_i         (clk_in),
        .rst_i         (rst_in),
        .lookup_word_i (pc_q[ADDR_WIDTH-1:2]),
        .hit_o         (cache_hit),
        .data_o        (cache_data),
        .fill_i        (cache_fill),
        .fill_word_i   (inst_addr_mc_out[ADDR_WIDTH-1:2]),
        .fill_data_i   (inst_mc_in)
    );
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q          <= StIdle;
            pc_q             <= RESET_PC;
            inst_req_mc_out  <= 1'b0;
            inst_addr_mc_out <= '0;
            rdy_iq_out       <= 1'b0;
            inst_iq_out      <= '0;
            pc_iq_out        <= '0;
        end else if (rdy_in) begin
            rdy_iq_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (refresh_rob_cdb_in) begin
                        pc_q <= pc_rob_cdb_in;
`ifdef ICACHE_EN
                    end else if (!iq_full_iq_in && cache_hit) begin
                        rdy_iq_out  <= 1'b1;
                        inst_iq_out <= cache_data;
                        pc_iq_out   <= pc_q;
                        pc_q        <= pc_seq;
`endif
                    end else if (!iq_full_iq_in) begin
                        inst_req_mc_out  <= 1'b1;
                        inst_addr_mc_out <= pc_q;
                        state_q          <= StWait;
                    end
                end
                StWait: begin
                    if (refresh_rob_cdb_in) begin
                        pc_q <= pc_rob_cdb_in;
                        if (inst_done_mc_in) begin
                            inst_req_mc_out <= 1'b0;
                            state_q         <= StIdle;
                        end else begin
                            state_q <= StFlush;
                        end
                    end else if (inst_done_mc_in) begin
                        rdy_iq_out      <= 1'b1;
                        inst_iq_out     <= inst_mc_in;
                        pc_iq_out       <= pc_q;
                        pc_q            <= pc_seq;
                        inst_req_mc_out <= 1'b0;
                        state_q         <= StIdle;
                    end
                end
                StFlush: begin
                    // The old request must complete before the redirected fetch can issue.
                    if (refresh_rob_cdb_in) begin
                        pc_q <= pc_rob_cdb_in;
                    end
                    if (inst_done_mc_in) begin
                        inst_req_mc_out <= 1'b0;
                        state_q         <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: latency-3 memory model, push scoreboard, scenario tasks.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_in;
    logic                  rdy_in;
    logic                  inst_req_mc_out;
    logic [ADDR_WIDTH-1:0] inst_addr_mc_out;
    logic [INST_WIDTH-1:0] inst_mc_in;
    logic                  inst_done_mc_in;
    logic [INST_WIDTH-1:0] inst_iq_out;
    logic [ADDR_WIDTH-1:0] pc_iq_out;
    logic                  rdy_iq_out;
    logic                  iq_full_iq_in;
    logic                  refresh_rob_cdb_in;
    logic [ADDR_WIDTH-1:0] pc_rob_cdb_in;

    inst_fetch dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .inst_req_mc_out    (inst_req_mc_out),
        .inst_addr_mc_out   (inst_addr_mc_out),
        .inst_mc_in         (inst_mc_in),
        .inst_done_mc_in    (inst_done_mc_in),
        .inst_iq_out        (inst_iq_out),
        .pc_iq_out          (pc_iq_out),
        .rdy_iq_out         (rdy_iq_out),
        .iq_full_iq_in      (iq_full_iq_in),
        .refresh_rob_cdb_in (refresh_rob_cdb_in),
        .pc_rob_cdb_in      (pc_rob_cdb_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } push_t;

    int checks   = 0;
    int failures = 0;

    push_t                 sb[$];
    logic [ADDR_WIDTH-1:0] req_log[$];
    int                    push_cnt = 0;

    // Memory model / refresh scheduler state
    bit                    mem_busy = 0;
    int                    mem_cnt  = 0;
    logic [ADDR_WIDTH-1:0] mem_addr = '0;
    int                    ref_when = -1;
    bit                    ref_now  = 0;
    logic [ADDR_WIDTH-1:0] ref_target = '0;
    bit                    prev_req = 0;
    logic [ADDR_WIDTH-1:0] prev_addr = '0;

    function automatic logic [INST_WIDTH-1:0] word_at(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] w;
        w = {a[23:0], 8'h13};
        return INST_WIDTH'(w);
    endfunction

    function automatic push_t mk(input logic [ADDR_WIDTH-1:0] a);
        push_t p;
        p.pc   = a;
        p.inst = word_at(a);
        return p;
    endfunction

    // Environment runs 1 time unit after each rising edge; scenario tasks drive on falling edges.
    always @(posedge clk) begin
        #1;
        if (rst_in) begin
            mem_busy           = 0;
            inst_done_mc_in    = 1'b0;
            refresh_rob_cdb_in = 1'b0;
            ref_when           = -1;
            ref_now            = 0;
            prev_req           = 0;
        end else if (rdy_in) begin
            if (rdy_iq_out) begin
                push_t exp;
                push_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL push_unexpected: got pc=%h inst=%h, required no push",
                             pc_iq_out, inst_iq_out);
                end else begin
                    exp = sb.pop_front();
                    if (pc_iq_out !== exp.pc || inst_iq_out !== exp.inst) begin
                        failures++;
                        $display("FAIL push_data: got pc=%h inst=%h, required pc=%h inst=%h",
                                 pc_iq_out, inst_iq_out, exp.pc, exp.inst);
                    end
                end
            end
            if (prev_req && inst_req_mc_out) begin
                checks++;
                if (inst_addr_mc_out !== prev_addr) begin
                    failures++;
                    $display("FAIL addr_stable: got %h, required %h", inst_addr_mc_out, prev_addr);
                end
            end
            inst_done_mc_in    = 1'b0;
            refresh_rob_cdb_in = 1'b0;
            if (ref_now) begin
                refresh_rob_cdb_in = 1'b1;
                pc_rob_cdb_in      = ref_target;
                ref_now            = 0;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    inst_done_mc_in = 1'b1;
                    inst_mc_in      = word_at(mem_addr);
                    mem_busy        = 0;
                end
                if (mem_cnt == ref_when) begin
                    refresh_rob_cdb_in = 1'b1;
                    pc_rob_cdb_in      = ref_target;
                    ref_when           = -1;
                end
            end else if (inst_req_mc_out) begin
                mem_busy = 1;
                mem_cnt  = 3;
                mem_addr = inst_addr_mc_out;
                req_log.push_back(inst_addr_mc_out);
            end
            prev_req  = inst_req_mc_out;
            prev_addr = inst_addr_mc_out;
        end
    end

    task automatic do_reset();
        rst_in        = 1'b1;
        iq_full_iq_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic wait_pushes(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (push_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        iq_full_iq_in = 1'b1;
    endtask

    task automatic test_reset();
        rdy_in = 1'b0;  // reset must win over a low rdy_in
        rst_in = 1'b1;
        iq_full_iq_in = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (inst_req_mc_out !== 1'b0) begin
            failures++; $display("FAIL reset_req: got %b, required 0", inst_req_mc_out);
        end
        if (inst_addr_mc_out !== '0) begin
            failures++; $display("FAIL reset_addr: got %h, required 0", inst_addr_mc_out);
        end
        if (rdy_iq_out !== 1'b0) begin
            failures++; $display("FAIL reset_rdy_iq: got %b, required 0", rdy_iq_out);
        end
        if (inst_iq_out !== '0) begin
            failures++; $display("FAIL reset_inst_iq: got %h, required 0", inst_iq_out);
        end
        if (pc_iq_out !== '0) begin
            failures++; $display("FAIL reset_pc_iq: got %h, required 0", pc_iq_out);
        end
        rdy_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic test_full_hold();
        bit seen_req = 0;
        repeat (6) begin
            @(negedge clk);
            if (inst_req_mc_out !== 1'b0) seen_req = 1;
        end
        checks++;
        if (seen_req) begin
            failures++; $display("FAIL full_hold_req: got request while full, required none");
        end
        sb.push_back(mk(32'h0));
        sb.push_back(mk(32'h4));
        sb.push_back(mk(32'h8));
        iq_full_iq_in = 1'b0;
        @(negedge clk);
        checks += 2;
        if (inst_req_mc_out !== 1'b1) begin
            failures++; $display("FAIL release_req: got %b, required 1", inst_req_mc_out);
        end
        if (inst_addr_mc_out !== RESET_PC) begin
            failures++; $display("FAIL release_addr: got %h, required %h", inst_addr_mc_out,
                                 RESET_PC);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        wait_pushes(3, ok);
        repeat (8) @(negedge clk);
        checks += 3;
        if (!ok) begin
            failures++; $display("FAIL seq_timeout: got %0d pushes, required 3", push_cnt);
        end
        if (req_log.size() != 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 ||
            req_log[2] !== 32'h8) begin
            failures++; $display("FAIL seq_reqs: got %0d requests, required 0,4,8", req_log.size());
        end
        if (sb.size() != 0) begin
            failures++; $display("FAIL seq_left: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_refresh(input logic [ADDR_WIDTH-1:0] old_pc,
                                input logic [ADDR_WIDTH-1:0] target, input int when);
        bit ok;
        int base = req_log.size();
        int pbase = push_cnt;
        ref_target = target;
        ref_when   = when;
        sb.push_back(mk(target));
        iq_full_iq_in = 1'b0;
        wait_pushes(pbase + 1, ok);
        repeat (8) @(negedge clk);
        checks += 3;
        if (!ok) begin
            failures++; $display("FAIL refresh_timeout: got %0d pushes, required %0d", push_cnt,
                                 pbase + 1);
        end
        if (req_log.size() != base + 2 || req_log[base] !== old_pc ||
            req_log[base+1] !== target) begin
            failures++; $display("FAIL refresh_reqs: got %0d new requests, required %h then %h",
                                 req_log.size() - base, old_pc, target);
        end
        if (push_cnt != pbase + 1) begin
            failures++; $display("FAIL refresh_pushes: got %0d, required %0d", push_cnt,
                                 pbase + 1);
        end
    endtask

    task automatic test_rdy_stall();
        bit ok = 0;
        bit held = 1;
        int pbase = push_cnt;
        sb.push_back(mk(32'h204));
        iq_full_iq_in = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_busy && mem_cnt == 2) begin
                ok = 1;
                break;
            end
        end
        rdy_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (inst_req_mc_out !== 1'b1 || inst_addr_mc_out !== 32'h204 ||
                rdy_iq_out !== 1'b0) held = 0;
        end
        rdy_in = 1'b1;
        checks += 2;
        if (!ok) begin
            failures++; $display("FAIL stall_setup: got no request in flight, required one");
        end
        if (!held) begin
            failures++; $display("FAIL stall_hold: got req=%b addr=%h, required 1 and 204",
                                 inst_req_mc_out, inst_addr_mc_out);
        end
        wait_pushes(pbase + 1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL stall_push: got %0d pushes, required %0d", push_cnt,
                                 pbase + 1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_refetch();
        bit ok;
        int rbase, pbase, exp_reqs;
        do_reset();
        for (int a = 0; a < 16; a += 4) sb.push_back(mk(ADDR_WIDTH'(a)));
        pbase = push_cnt;
        iq_full_iq_in = 1'b0;
        wait_pushes(pbase + 4, ok);
        repeat (6) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL fill_timeout: got %0d pushes, required %0d", push_cnt,
                                 pbase + 4);
        end
        ref_target = '0;
        ref_now    = 1;
        repeat (4) @(negedge clk);
        rbase = req_log.size();
        pbase = push_cnt;
        for (int a = 0; a < 20; a += 4) sb.push_back(mk(ADDR_WIDTH'(a)));
        iq_full_iq_in = 1'b0;
        wait_pushes(pbase + 5, ok);
        repeat (8) @(negedge clk);
`ifdef ICACHE_EN
        exp_reqs = 1;
`else
        exp_reqs = 5;
`endif
        checks += 3;
        if (!ok) begin
            failures++; $display("FAIL refetch_timeout: got %0d pushes, required %0d", push_cnt,
                                 pbase + 5);
        end
        if (req_log.size() - rbase != exp_reqs) begin
            failures++; $display("FAIL refetch_reqs: got %0d requests, required %0d",
                                 req_log.size() - rbase, exp_reqs);
        end else if (req_log[req_log.size()-1] !== 32'h10) begin
            failures++; $display("FAIL refetch_last: got %h, required 10",
                                 req_log[req_log.size()-1]);
        end
        if (sb.size() != 0) begin
            failures++; $display("FAIL refetch_left: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        inst_mc_in         = '0;
        inst_done_mc_in    = 1'b0;
        refresh_rob_cdb_in = 1'b0;
        pc_rob_cdb_in      = '0;
        test_reset();
        test_full_hold();
        test_sequential();
        test_refresh(32'hC, 32'h100, 2);
        test_refresh(32'h104, 32'h200, 0);
        test_rdy_stall();
        test_refetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish within bound");
        $fatal(1, "timeout");
    end

endmodule
